// File: rtl/e203_irq_inject_sched_pkg.sv
// Shared types and defaults for the e203 interrupt / bus-error stimulus scheduler.
// State encodings, LFSR polynomial and the default handler PCs live here.
package e203_irq_inject_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    ASSERT = 2'd2
  } chan_st_e;

  typedef enum logic [1:0] {
    BE_IDLE = 2'd0,
    BE_LO   = 2'd1,
    BE_HI   = 2'd2
  } be_st_e;

  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
  localparam logic [31:0] DEF_SEED   = 32'hACE1_2357;
  localparam logic [31:0] DEF_ARM    = 32'h8000_015C;
  localparam logic [31:0] DEF_TOHOST = 32'h8000_0086;
  localparam logic [31:0] DEF_EXT    = 32'h8000_00A6;
  localparam logic [31:0] DEF_SFT    = 32'h8000_00BE;
  localparam logic [31:0] DEF_TMR    = 32'h8000_00D6;

  // Galois form, shifting right
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/e203_irq_inject_chan.sv
// One interrupt channel: idle, pseudo-random delay, then hold the line
// until the handler commits its pre-mret PC.
module e203_irq_inject_chan
  import e203_irq_inject_sched_pkg::*;
#(
  parameter int unsigned     PC_W   = 32,
  parameter logic [PC_W-1:0] ACK_PC = DEF_EXT[PC_W-1:0],
  parameter int unsigned     DLY_W  = 10
) (
  input  logic             hfclk,
  input  logic             rst_n,
  input  logic             inj_en,
  input  logic             arm,
  input  logic             stop,
  input  logic             cmt_valid,
  input  logic [PC_W-1:0]  cmt_pc,
  input  logic [DLY_W-1:0] slice,
  output logic             irq
);

  localparam logic [DLY_W:0] ONE = {{DLY_W{1'b0}}, 1'b1};

  chan_st_e       st, st_nxt;
  logic [DLY_W:0] cnt, cnt_nxt;
  logic [DLY_W:0] load;
  logic           ack;

  assign load = {1'b0, slice} + ONE;
  assign ack  = cmt_valid & (cmt_pc == ACK_PC);

  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    if (inj_en) begin
      unique case (st)
        IDLE: begin
          if (arm & ~stop) begin
            st_nxt  = DELAY;
            cnt_nxt = load;
          end
        end
        DELAY: begin
          if (cnt == ONE) st_nxt = ASSERT;
          else            cnt_nxt = cnt - ONE;
        end
        ASSERT: begin
          if (ack) begin
            if (stop) begin
              st_nxt = IDLE;
            end else begin
              st_nxt  = DELAY;
              cnt_nxt = load;
            end
          end
        end
        default: st_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge hfclk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= IDLE;
      cnt <= '0;
      irq <= 1'b0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
      irq <= inj_en & (st_nxt == ASSERT);
    end
  end

endmodule

// File: rtl/e203_irq_inject_sched.sv
// Clocked stimulus controller for the e203 sim top: drives ext/sft/tmr
// interrupts and ITCM bus-error windows from one LFSR.
module e203_irq_inject_sched
  import e203_irq_inject_sched_pkg::*;
#(
  parameter int unsigned     PC_W       = 32,
  parameter logic [PC_W-1:0] PC_ARM     = DEF_ARM[PC_W-1:0],
  parameter logic [PC_W-1:0] PC_TOHOST  = DEF_TOHOST[PC_W-1:0],
  parameter logic [PC_W-1:0] PC_EXT_ACK = DEF_EXT[PC_W-1:0],
  parameter logic [PC_W-1:0] PC_SFT_ACK = DEF_SFT[PC_W-1:0],
  parameter logic [PC_W-1:0] PC_TMR_ACK = DEF_TMR[PC_W-1:0],
  parameter int unsigned     DLY_W      = 10,
  parameter int unsigned     BE_LO_W    = 5,
  parameter int unsigned     BE_HI_W    = 8,
  parameter int unsigned     STOP_CNT   = 32,
  parameter int unsigned     END_CNT    = 8,
  parameter logic [31:0]     SEED       = DEF_SEED
) (
  input  logic            hfclk,
  input  logic            rst_n,
  input  logic            inj_en,
  input  logic            be_en,
  input  logic            cmt_valid,
  input  logic [PC_W-1:0] cmt_pc,
  input  logic            status_mie,
  input  logic            itcm_rsp_read,
  output logic            ext_irq,
  output logic            sft_irq,
  output logic            tmr_irq,
  output logic            itcm_bus_err,
  output logic [31:0]     tohost_cnt,
  output logic            armed,
  output logic            done
);

  localparam int unsigned    BE_CW  = BE_HI_W + 1;
  localparam logic [BE_CW-1:0] BE_ONE = {{(BE_CW-1){1'b0}}, 1'b1};

  logic [31:0]      lfsr;
  logic             stop;
  logic             arm_hit, th_hit;
  be_st_e           be_st, be_nxt;
  logic [BE_CW-1:0] be_cnt, be_cnt_nxt;
  logic [BE_CW-1:0] be_lo_ld, be_hi_ld;
  logic             be_hi_q;

  assign arm_hit = cmt_valid & (cmt_pc == PC_ARM);
  assign th_hit  = cmt_valid & (cmt_pc == PC_TOHOST);

  assign be_lo_ld = {{(BE_CW-BE_LO_W){1'b0}}, lfsr[BE_LO_W-1:0]} + BE_ONE;
  assign be_hi_ld = {1'b0, lfsr[20+BE_HI_W-1:20]} + BE_ONE;

  always_ff @(posedge hfclk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr       <= SEED;
      armed      <= 1'b0;
      tohost_cnt <= '0;
      stop       <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (inj_en) lfsr <= lfsr_step(lfsr);
      if (arm_hit) armed <= 1'b1;
      if (th_hit && tohost_cnt != '1) tohost_cnt <= tohost_cnt + 32'd1;
      stop <= (tohost_cnt > STOP_CNT);
      done <= (tohost_cnt >= END_CNT) & ~ext_irq & ~sft_irq & ~tmr_irq;
    end
  end

  e203_irq_inject_chan #(
    .PC_W(PC_W), .ACK_PC(PC_EXT_ACK), .DLY_W(DLY_W)
  ) u_ext (
    .hfclk(hfclk), .rst_n(rst_n), .inj_en(inj_en),
    .arm(armed), .stop(stop),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc),
    .slice(lfsr[DLY_W-1:0]), .irq(ext_irq)
  );

  e203_irq_inject_chan #(
    .PC_W(PC_W), .ACK_PC(PC_SFT_ACK), .DLY_W(DLY_W)
  ) u_sft (
    .hfclk(hfclk), .rst_n(rst_n), .inj_en(inj_en),
    .arm(armed), .stop(stop),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc),
    .slice(lfsr[2*DLY_W-1:DLY_W]), .irq(sft_irq)
  );

  e203_irq_inject_chan #(
    .PC_W(PC_W), .ACK_PC(PC_TMR_ACK), .DLY_W(DLY_W)
  ) u_tmr (
    .hfclk(hfclk), .rst_n(rst_n), .inj_en(inj_en),
    .arm(armed), .stop(stop),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc),
    .slice(lfsr[3*DLY_W-1:2*DLY_W]), .irq(tmr_irq)
  );

  always_comb begin
    be_nxt     = be_st;
    be_cnt_nxt = be_cnt;
    if (inj_en) begin
      unique case (be_st)
        BE_IDLE: begin
          if (armed & be_en & ~stop) begin
            be_nxt     = BE_LO;
            be_cnt_nxt = be_lo_ld;
          end
        end
        BE_LO: begin
          if (be_cnt == BE_ONE) begin
            be_nxt     = BE_HI;
            be_cnt_nxt = be_hi_ld;
          end else begin
            be_cnt_nxt = be_cnt - BE_ONE;
          end
        end
        BE_HI: begin
          if (be_cnt == BE_ONE) begin
            if (stop | ~be_en) begin
              be_nxt = BE_IDLE;
            end else begin
              be_nxt     = BE_LO;
              be_cnt_nxt = be_lo_ld;
            end
          end else begin
            be_cnt_nxt = be_cnt - BE_ONE;
          end
        end
        default: be_nxt = BE_IDLE;
      endcase
    end
  end

  always_ff @(posedge hfclk or negedge rst_n) begin
    if (!rst_n) begin
      be_st   <= BE_IDLE;
      be_cnt  <= '0;
      be_hi_q <= 1'b0;
    end else begin
      be_st   <= be_nxt;
      be_cnt  <= be_cnt_nxt;
      be_hi_q <= inj_en & (be_nxt == BE_HI);
    end
  end

  // Same-cycle gating against the live response so only real reads fault
  assign itcm_bus_err = be_hi_q & status_mie & itcm_rsp_read;

endmodule

// File: tb/tb_e203_irq_inject_sched.sv
// Directed bench for e203_irq_inject_sched: arming, delays, ack, stop,
// bus-error gating, enable freeze, done and async reset.
module tb_e203_irq_inject_sched;

  localparam logic [31:0] SEED    = 32'h00E0_1009;
  localparam logic [31:0] TAPS    = 32'h8020_0003;
  localparam logic [31:0] P_ARM   = 32'h8000_015C;
  localparam logic [31:0] P_TOH   = 32'h8000_0086;
  localparam logic [31:0] P_EXT   = 32'h8000_00A6;
  localparam logic [31:0] P_SFT   = 32'h8000_00BE;
  localparam logic [31:0] P_TMR   = 32'h8000_00D6;

  logic        hfclk;
  logic        rst_n;
  logic        inj_en;
  logic        be_en;
  logic        cmt_valid;
  logic [31:0] cmt_pc;
  logic        status_mie;
  logic        itcm_rsp_read;
  logic        ext_irq;
  logic        sft_irq;
  logic        tmr_irq;
  logic        itcm_bus_err;
  logic [31:0] tohost_cnt;
  logic        armed;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] lfsr_m;

  e203_irq_inject_sched #(.SEED(SEED)) dut (
    .hfclk(hfclk),
    .rst_n(rst_n),
    .inj_en(inj_en),
    .be_en(be_en),
    .cmt_valid(cmt_valid),
    .cmt_pc(cmt_pc),
    .status_mie(status_mie),
    .itcm_rsp_read(itcm_rsp_read),
    .ext_irq(ext_irq),
    .sft_irq(sft_irq),
    .tmr_irq(tmr_irq),
    .itcm_bus_err(itcm_bus_err),
    .tohost_cnt(tohost_cnt),
    .armed(armed),
    .done(done)
  );

  initial hfclk = 1'b0;
  always #5 hfclk = ~hfclk;

  // Reference LFSR used to predict reload delays and burst lengths
  always @(posedge hfclk or negedge rst_n) begin
    if (!rst_n) lfsr_m <= SEED;
    else if (inj_en)
      lfsr_m <= lfsr_m[0] ? ((lfsr_m >> 1) ^ TAPS) : (lfsr_m >> 1);
  end

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: got %0b want %0b", tag, obs, exp_v);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp_v);
    end
  endtask

  task automatic commit(input logic [31:0] pc);
    cmt_valid = 1'b1;
    cmt_pc    = pc;
    @(negedge hfclk);
    cmt_valid = 1'b0;
    cmt_pc    = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge hfclk);
    @(negedge hfclk);
    rst_n = 1'b1;
  endtask

  initial begin
    int   n;
    int   exp_d;
    int   hl;
    logic seen;

    rst_n = 1'b0; inj_en = 1'b0; be_en = 1'b0; cmt_valid = 1'b0;
    cmt_pc = '0; status_mie = 1'b0; itcm_rsp_read = 1'b0;

    // reset state
    @(negedge hfclk);
    chk1("rst_ext", ext_irq, 1'b0);
    chk1("rst_armed", armed, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk32("rst_tohost", tohost_cnt, 32'd0);

    // enabled but never armed: nothing may fire
    inj_en = 1'b1; be_en = 1'b1; status_mie = 1'b1; itcm_rsp_read = 1'b1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (5000) begin
      @(negedge hfclk);
      seen = seen | ext_irq | sft_irq | tmr_irq | itcm_bus_err;
    end
    chk1("unarmed_quiet", seen, 1'b0);
    chk1("unarmed_armed", armed, 1'b0);
    chk32("unarmed_tohost", tohost_cnt, 32'd0);

    // arm with LFSR frozen so the seed slices give delays 10/5/15
    inj_en = 1'b0; be_en = 1'b0; status_mie = 1'b0; itcm_rsp_read = 1'b0;
    do_reset();
    commit(P_ARM);
    chk1("arm_set", armed, 1'b1);
    chk1("arm_no_irq", ext_irq, 1'b0);
    inj_en = 1'b1;
    @(negedge hfclk);
    for (int i = 1; i <= 15; i++) begin
      @(negedge hfclk);
      chk1("ext_dly", ext_irq, i >= 10);
      chk1("sft_dly", sft_irq, i >= 5);
      chk1("tmr_dly", tmr_irq, i >= 15);
    end

    // enable freeze: lines drop, state holds, re-enable restores ASSERT
    inj_en = 1'b0;
    @(negedge hfclk);
    chk1("frz_sft", sft_irq, 1'b0);
    chk1("frz_ext", ext_irq, 1'b0);
    repeat (3) @(negedge hfclk);
    chk1("frz_hold", sft_irq, 1'b0);
    inj_en = 1'b1;
    @(negedge hfclk);
    chk1("resume_sft", sft_irq, 1'b1);
    repeat (5) @(negedge hfclk);
    chk1("resume_held", sft_irq, 1'b1);

    // ext ack: drops next cycle, reloads DELAY from current LFSR slice
    exp_d = int'(lfsr_m[9:0]) + 1;
    commit(P_EXT);
    chk1("ext_ack_drop", ext_irq, 1'b0);
    n = 0;
    while (!ext_irq && n < 1200) begin
      @(negedge hfclk);
      n++;
    end
    chk32("ext_reload", n, exp_d);

    // 33 tohost commits push past the stop threshold
    cmt_valid = 1'b1; cmt_pc = P_TOH;
    repeat (33) @(negedge hfclk);
    cmt_valid = 1'b0; cmt_pc = '0;
    @(negedge hfclk);
    chk32("tohost_33", tohost_cnt, 32'd33);
    chk1("tmr_held", tmr_irq, 1'b1);
    commit(P_TMR);
    chk1("tmr_ack", tmr_irq, 1'b0);
    commit(P_SFT);
    chk1("sft_ack", sft_irq, 1'b0);
    commit(P_EXT);
    chk1("ext_ack2", ext_irq, 1'b0);
    chk1("done_lag", done, 1'b0);
    @(negedge hfclk);
    chk1("done_stop", done, 1'b1);
    seen = 1'b0;
    repeat (1100) begin
      @(negedge hfclk);
      seen = seen | ext_irq | sft_irq | tmr_irq;
    end
    chk1("stopped_quiet", seen, 1'b0);
    chk1("done_keep", done, 1'b1);

    // bus-error window: lo burst 10 from seed, hi burst from LFSR
    inj_en = 1'b0; be_en = 1'b1; status_mie = 1'b0; itcm_rsp_read = 1'b1;
    do_reset();
    commit(P_ARM);
    inj_en = 1'b1;
    @(negedge hfclk);
    repeat (9) @(negedge hfclk);
    hl = int'(lfsr_m[27:20]) + 1;
    status_mie = 1'b1;
    #1 chk1("be_lo", itcm_bus_err, 1'b0);
    status_mie = 1'b0;
    @(negedge hfclk);
    chk1("be_hi_nomie", itcm_bus_err, 1'b0);
    status_mie = 1'b1;
    #1 chk1("be_hi_mie", itcm_bus_err, 1'b1);
    itcm_rsp_read = 1'b0;
    #1 chk1("be_hi_wr", itcm_bus_err, 1'b0);
    itcm_rsp_read = 1'b1;
    repeat (hl - 1) @(negedge hfclk);
    chk1("be_hi_last", itcm_bus_err, 1'b1);
    @(negedge hfclk);
    chk1("be_hi_end", itcm_bus_err, 1'b0);

    // async reset while ext is asserted
    chk1("pre_rst_ext", ext_irq, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("arst_ext", ext_irq, 1'b0);
    chk1("arst_sft", sft_irq, 1'b0);
    chk1("arst_tmr", tmr_irq, 1'b0);
    chk1("arst_be", itcm_bus_err, 1'b0);
    chk1("arst_armed", armed, 1'b0);
    @(negedge hfclk);
    rst_n = 1'b1;

    // done after 8 tohost commits with no interrupts
    be_en = 1'b0;
    cmt_valid = 1'b1; cmt_pc = P_TOH;
    repeat (7) @(negedge hfclk);
    chk32("tohost_7", tohost_cnt, 32'd7);
    @(negedge hfclk);
    cmt_valid = 1'b0; cmt_pc = '0;
    chk32("tohost_8", tohost_cnt, 32'd8);
    chk1("done_pre", done, 1'b0);
    @(negedge hfclk);
    chk1("done_8", done, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
